wbm_arb: RTL and testbench
==========================

# wbm_arb

Wishbone master-port arbiter for the DMA engine. It shares the single 64-bit-data system bus master between the descriptor/control sequencer (the ctrl requester, `gnt4` slot) and the channel data movers. Each complete bus cycle (cyc high to cyc low) is granted round-robin and is never pre-empted. A watchdog aborts owners whose slave never responds. It sits between the requesters' `wbs_*` buses and the top-level `wbm_*` pins.

## Interface

Parameters:
- `NREQ`, 5, number of requesters. Index 4 is ctrl.
- `TIMEOUT`, 1024, cycles with stb high and no ack/err/rty before abort. 0 disables the watchdog.
- `TW`, 11, width of the watchdog counter. Must hold `TIMEOUT`.

Ports (requester buses are packed, requester i occupies slice i):
- `wb_clk_i` in 1: clock.
- `wb_rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `req_cyc`, `req_stb`, `req_we`, `req_cab` in NREQ each: requester cycle, strobe, write enable and burst flags.
- `req_sel` in 4*NREQ: byte selects.
- `req_adr`, `req_dat`, `req_dat64` in 32*NREQ each: address, low write data, high write data.
- `gnt` out NREQ: one-hot grant.
- `req_ack`, `req_err`, `req_rty` out NREQ each: per-requester response.
- `req_dat_o`, `req_dat64_o` out 32 each: read data, broadcast to all requesters.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`, `wbm_cab_o` out 1 each: master control.
- `wbm_sel_o` out 4; `wbm_adr_o`, `wbm_dat_o`, `wbm_dat64_o` out 32 each: master select, address and write data.
- `wbm_dat_i`, `wbm_dat64_i` in 32 each; `wbm_ack_i`, `wbm_err_i`, `wbm_rty_i` in 1 each: slave return path.
- `arb_state` out 2: debug, equals the current state encoding.

## Operation

- States: `IDLE`=0, `BUSY`=1, `ABORT`=2.
- `IDLE`: if any `req_cyc` is high, pick the first requester at or after `ptr` (wrapping modulo NREQ). Register `gnt` to that one-hot value, store its index in `own`, go to `BUSY`. If none are high, stay in `IDLE` with `gnt`=0.
- `BUSY`: master outputs are combinationally muxed from slice `own`.
  - `wbm_cyc_o` = `req_cyc[own]`; `wbm_stb_o` = `req_stb[own]`.
  - Master responses route only to `own`: `req_ack[own]` = `wbm_ack_i`, and the same for err and rty. All other responses are 0.
  - When `req_cyc[own]` goes low: clear `gnt`, set `ptr` = `own`+1 (wrap at NREQ to 0), go to `IDLE`.
- Watchdog: `wdog` counts up in `BUSY` while stb is high and ack, err and rty are all low. It clears on any response, on cyc low, and outside `BUSY`. When `wdog` reaches `TIMEOUT`:
  - pulse `req_err[own]` for one cycle;
  - go to `ABORT`.
- `ABORT`: `wbm_cyc_o` and `wbm_stb_o` are forced to 0 and `gnt` stays held. When `req_cyc[own]` goes low, advance `ptr` as in `BUSY` and go to `IDLE`.
- Outside `BUSY`: all master control outputs are 0. Address, data and sel still mux slice `own` (don't-care).
- Simultaneous events:
  - cyc drop and timeout in the same cycle: the cyc drop wins. No err, go to `IDLE`.
  - `wbm_ack_i` and timeout in the same cycle: the ack wins and the counter clears.
  - slave err or rty is passed through unchanged. The arbiter does not retry; the owner keeps the bus.
- Reset (asynchronous, any state): state=`IDLE`, `gnt`=0, `own`=0, `ptr`=0, `wdog`=0. This immediately forces `wbm_cyc_o` and `wbm_stb_o` to 0 and all `req_ack`, `req_err` and `req_rty` to 0.

## Timing

- Grant latency: `req_cyc` high in cycle n gives `gnt` high in n+1. The master bus sees cyc/stb from n+1, combinationally.
- Release: `req_cyc[own]` low in cycle m puts the state in `IDLE` at m+1. A new grant is visible at m+2, so there is one dead cycle between owners.
- Each requester must hold `req_cyc` and `req_stb` from assertion until granted. Asserting cyc without a grant is legal; the stb is simply not seen.
- Bursts (`cab`=1) proceed at one beat per ack with no arbiter-added wait states.
- Timeout fires on the cycle where `wdog`=`TIMEOUT`. `req_err` is high for exactly that cycle.

## Structure

- Shared package `ssdma_pkg` holds the state encodings `ARB_IDLE`, `ARB_BUSY` and `ARB_ABORT`, plus the default `TIMEOUT`.
- One sub-module, `rr_pick`: combinational round-robin picker with inputs `req[NREQ]` and `ptr` and outputs a one-hot result, its index and a valid flag. Instantiated once.
- Everything else (FSM, watchdog, muxes) lives in `wbm_arb`.

## Test plan

- Single requester: `req_cyc[4]` high at cycle 0. Then `gnt`=5'b10000 at cycle 1, `wbm_adr_o`=`req_adr[4]`, 4 acks are routed only to `req_ack[4]`; cyc low at cycle 6 gives state `IDLE` at 7 and `ptr`=0.
- Fairness: all 5 `req_cyc` held high, each releasing after 1 beat. Grant order is 0,1,2,3,4,0 with one dead cycle between owners.
- Timeout with `TIMEOUT`=8: owner 2 strobes and the slave is silent. `req_err[2]` pulses on the 8th stalled cycle, `wbm_cyc_o`=0 from the next cycle, owner 2 drops cyc, and `gnt` moves to requester 3.
- Race: owner drops cyc on the same cycle `wdog`=`TIMEOUT`. No `req_err` and a normal release.
- Slave `wbm_rty_i` pulses: passed to the owner only, `wdog` clears, and the grant is retained.
- Async reset asserted mid-burst (beat 2 of 4): `gnt`=0, `wbm_cyc_o`=0 in the same cycle. After release, the first grant goes to the lowest requesting index (`ptr`=0).

Source files
------------

// File: rtl/ssdma_pkg.sv
// ---------------------------------------------------------------------------
// ssdma_pkg : shared DMA types, arbiter state encodings, defaults.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ssdma_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_e;

  localparam int TIMEOUT_DEFAULT = 1024;
  localparam int TW_DEFAULT      = 11;

  function automatic int rr_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wbm_arb_if.sv
// ---------------------------------------------------------------------------
// wbm_arb_if : requester buses plus shared Wishbone master pins.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface wbm_arb_if #(
  parameter int NREQ = 5
);
  logic [NREQ-1:0]      req_cyc, req_stb, req_we, req_cab;
  logic [4*NREQ-1:0]    req_sel;
  logic [32*NREQ-1:0]   req_adr, req_dat, req_dat64;
  logic [NREQ-1:0]      gnt, req_ack, req_err, req_rty;
  logic [31:0]          req_dat_o, req_dat64_o;
  logic                 wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o;
  logic [3:0]           wbm_sel_o;
  logic [31:0]          wbm_adr_o, wbm_dat_o, wbm_dat64_o;
  logic [31:0]          wbm_dat_i, wbm_dat64_i;
  logic                 wbm_ack_i, wbm_err_i, wbm_rty_i;

  // Arbiter view: consumes requester buses, drives the master pins.
  modport master (
    input  req_cyc, req_stb, req_we, req_cab, req_sel, req_adr, req_dat, req_dat64,
    input  wbm_dat_i, wbm_dat64_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
    output gnt, req_ack, req_err, req_rty, req_dat_o, req_dat64_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o, wbm_sel_o,
    output wbm_adr_o, wbm_dat_o, wbm_dat64_o
  );

  modport slave (
    output req_cyc, req_stb, req_we, req_cab, req_sel, req_adr, req_dat, req_dat64,
    output wbm_dat_i, wbm_dat64_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
    input  gnt, req_ack, req_err, req_rty, req_dat_o, req_dat64_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o, wbm_sel_o,
    input  wbm_adr_o, wbm_dat_o, wbm_dat64_o
  );
endinterface

`default_nettype wire

// File: rtl/wbm_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational first-at-or-after-ptr round-robin picker.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int NREQ = 5,
  parameter int IW   = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  always_comb begin
    int j;
    j        = 0;
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!valid_o && req_i[j]) begin
        valid_o     = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = IW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wbm_arb.sv
// ---------------------------------------------------------------------------
// wbm_arb : round-robin Wishbone master-port arbiter with stall watchdog.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wbm_arb
  import ssdma_pkg::*;
#(
  parameter int NREQ    = 5,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TW      = TW_DEFAULT
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  wbm_arb_if.master        bus,
  output logic [1:0]       arb_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   own_q, own_d, ptr_q, ptr_d;
  logic [TW-1:0]   wdog_q, wdog_d;

  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;

  logic            own_cyc, own_stb, own_we, own_cab;
  logic [3:0]      own_sel;
  logic [31:0]     own_adr, own_dat, own_dat64;
  logic            busy, any_rsp, stall, timeout;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i    (bus.req_cyc),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_cab   = 1'b0;
    own_sel   = '0;
    own_adr   = '0;
    own_dat   = '0;
    own_dat64 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (own_q == IW'(i)) begin
        own_cyc   = bus.req_cyc[i];
        own_stb   = bus.req_stb[i];
        own_we    = bus.req_we[i];
        own_cab   = bus.req_cab[i];
        own_sel   = bus.req_sel[4*i +: 4];
        own_adr   = bus.req_adr[32*i +: 32];
        own_dat   = bus.req_dat[32*i +: 32];
        own_dat64 = bus.req_dat64[32*i +: 32];
      end
    end
  end

  assign busy    = (state_q == ARB_BUSY);
  assign any_rsp = bus.wbm_ack_i | bus.wbm_err_i | bus.wbm_rty_i;
  assign stall   = busy && own_cyc && own_stb && !any_rsp;
  // Fires on the stalled cycle that brings the count up to TIMEOUT.
  assign timeout = (TIMEOUT != 0) && stall && (wdog_q == TW'(TIMEOUT - 1));

  always_comb begin
    wdog_d = wdog_q;
    if (!busy || !own_cyc || any_rsp || timeout) begin
      wdog_d = '0;
    end else if (own_stb && (TIMEOUT != 0)) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          gnt_d   = pick_onehot;
          own_d   = pick_idx;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY, ARB_ABORT: begin
        // A cyc drop always wins over a coincident timeout.
        if (!own_cyc) begin
          gnt_d   = '0;
          ptr_d   = IW'(rr_wrap_inc(int'(own_q), NREQ));
          state_d = ARB_IDLE;
        end else if (timeout) begin
          state_d = ARB_ABORT;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.wbm_cyc_o   = busy & own_cyc;
  assign bus.wbm_stb_o   = busy & own_stb;
  assign bus.wbm_we_o    = busy & own_we;
  assign bus.wbm_cab_o   = busy & own_cab;
  assign bus.wbm_sel_o   = own_sel;
  assign bus.wbm_adr_o   = own_adr;
  assign bus.wbm_dat_o   = own_dat;
  assign bus.wbm_dat64_o = own_dat64;
  assign bus.req_dat_o   = bus.wbm_dat_i;
  assign bus.req_dat64_o = bus.wbm_dat64_i;
  assign arb_state       = state_q;

  always_comb begin
    bus.req_ack = '0;
    bus.req_err = '0;
    bus.req_rty = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (own_q == IW'(i)) begin
        bus.req_ack[i] = busy && bus.wbm_ack_i;
        bus.req_err[i] = (busy && bus.wbm_err_i) || timeout;
        bus.req_rty[i] = busy && bus.wbm_rty_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wbm_arb.sv
// ---------------------------------------------------------------------------
// tb_wbm_arb : directed vector and sequence bench for wbm_arb.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wbm_arb;

  localparam int NREQ    = 5;
  localparam int TIMEOUT = 8;
  localparam int TW      = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] arb_state;
  int         nchk  = 0;
  int         nerr  = 0;

  always #5 clk = ~clk;

  wbm_arb_if #(.NREQ(NREQ)) bus ();

  wbm_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .bus       (bus),
    .arb_state (arb_state)
  );

  typedef struct {
    logic [4:0] cyc;
    logic       ack, err, rty;
    logic [4:0] gnt, rack, rerr, rrty;
    logic       mcyc;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [4:0] cyc, input logic ack, input logic err,
                              input logic rty, input logic [4:0] gnt, input logic [4:0] rack,
                              input logic [4:0] rerr, input logic [4:0] rrty,
                              input logic mcyc, input logic [1:0] st);
    vec_t v;
    v.cyc = cyc; v.ack = ack; v.err = err; v.rty = rty;
    v.gnt = gnt; v.rack = rack; v.rerr = rerr; v.rrty = rrty;
    v.mcyc = mcyc; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] c, input logic a, input logic e, input logic r);
    bus.req_cyc   = c;
    bus.req_stb   = c;
    bus.wbm_ack_i = a;
    bus.wbm_err_i = e;
    bus.wbm_rty_i = r;
  endtask

  task automatic do_reset();
    drive(5'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // One stalled cycle of owner o; err expected only when last is set.
  task automatic stall_chk(input string tag, input int o, input int s, input bit last);
    @(negedge clk);
    chk($sformatf("%s s%0d gnt", tag, s), bus.gnt, 32'(1 << o));
    chk($sformatf("%s s%0d err", tag, s), bus.req_err, last ? 32'(1 << o) : 32'd0);
    chk($sformatf("%s s%0d st", tag, s), arb_state, 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int order[6];
    logic [4:0] cur;
    order = '{0, 1, 2, 3, 4, 0};

    for (int i = 0; i < NREQ; i++) begin
      bus.req_adr[32*i +: 32]   = 32'hA000_0000 + 32'(i);
      bus.req_dat[32*i +: 32]   = 32'hD000_0000 + 32'(i);
      bus.req_dat64[32*i +: 32] = 32'hD640_0000 + 32'(i);
      bus.req_sel[4*i +: 4]     = 4'hF;
    end
    bus.req_we      = 5'b0;
    bus.req_cab     = 5'b10000;
    bus.wbm_dat_i   = 32'h1234_5678;
    bus.wbm_dat64_i = 32'h9ABC_DEF0;
    drive(5'b0, 1'b0, 1'b0, 1'b0);

    // Reset state while held in reset.
    repeat (2) @(posedge clk);
    #1;
    chk("rst gnt", bus.gnt, 32'd0);
    chk("rst mcyc", bus.wbm_cyc_o, 32'd0);
    chk("rst state", arb_state, 32'd0);
    chk("rdat bcast", bus.req_dat_o, 32'h1234_5678);
    rst_n = 1'b1;

    //      cyc       a  e  r  gnt       rack      rerr      rrty      mc st
    tbl.push_back(mk(5'b10000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
    tbl.push_back(mk(5'b10000, 1, 0, 0, 5'b10000, 5'b10000, 5'b00000, 5'b00000, 1, 1));
    tbl.push_back(mk(5'b10000, 1, 0, 0, 5'b10000, 5'b10000, 5'b00000, 5'b00000, 1, 1));
    tbl.push_back(mk(5'b10000, 0, 0, 0, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 1, 1));
    tbl.push_back(mk(5'b10000, 1, 0, 0, 5'b10000, 5'b10000, 5'b00000, 5'b00000, 1, 1));
    tbl.push_back(mk(5'b10000, 1, 0, 0, 5'b10000, 5'b10000, 5'b00000, 5'b00000, 1, 1));
    tbl.push_back(mk(5'b00000, 0, 0, 0, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
    // ptr wrapped to 0: requester 0 beats 4.
    tbl.push_back(mk(5'b10001, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
    tbl.push_back(mk(5'b10001, 1, 0, 0, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 1, 1));
    tbl.push_back(mk(5'b10000, 0, 0, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 0, 1));
    tbl.push_back(mk(5'b10000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
    tbl.push_back(mk(5'b10000, 1, 0, 0, 5'b10000, 5'b10000, 5'b00000, 5'b00000, 1, 1));
    tbl.push_back(mk(5'b00000, 0, 0, 0, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
    // Requester 1: rty/err pass-through, each clearing the watchdog.
    tbl.push_back(mk(5'b00010, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
    tbl.push_back(mk(5'b00010, 0, 0, 1, 5'b00010, 5'b00000, 5'b00000, 5'b00010, 1, 1));
    tbl.push_back(mk(5'b00010, 0, 1, 0, 5'b00010, 5'b00000, 5'b00010, 5'b00000, 1, 1));
    for (int s = 0; s < 7; s++)
      tbl.push_back(mk(5'b00010, 0, 0, 0, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 1, 1));
    tbl.push_back(mk(5'b00010, 0, 0, 1, 5'b00010, 5'b00000, 5'b00000, 5'b00010, 1, 1));
    for (int s = 0; s < 7; s++)
      tbl.push_back(mk(5'b00010, 0, 0, 0, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 1, 1));
    tbl.push_back(mk(5'b00000, 0, 0, 0, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].cyc, tbl[i].ack, tbl[i].err, tbl[i].rty);
      @(negedge clk);
      chk($sformatf("vec%0d gnt", i), bus.gnt, 32'(tbl[i].gnt));
      chk($sformatf("vec%0d ack", i), bus.req_ack, 32'(tbl[i].rack));
      chk($sformatf("vec%0d err", i), bus.req_err, 32'(tbl[i].rerr));
      chk($sformatf("vec%0d rty", i), bus.req_rty, 32'(tbl[i].rrty));
      chk($sformatf("vec%0d mcyc", i), bus.wbm_cyc_o, 32'(tbl[i].mcyc));
      chk($sformatf("vec%0d mstb", i), bus.wbm_stb_o, 32'(tbl[i].mcyc));
      chk($sformatf("vec%0d st", i), arb_state, 32'(tbl[i].st));
      tick();
    end

    // Fairness: all requesting, order 0,1,2,3,4,0 with one dead cycle.
    do_reset();
    cur = 5'h1F;
    drive(cur, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("fair start gnt", bus.gnt, 32'd0);
    tick();
    for (int j = 0; j < 6; j++) begin
      drive(cur, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("fair%0d gnt", j), bus.gnt, 32'(1 << order[j]));
      chk($sformatf("fair%0d ack", j), bus.req_ack, 32'(1 << order[j]));
      chk($sformatf("fair%0d adr", j), bus.wbm_adr_o, 32'hA000_0000 + 32'(order[j]));
      chk($sformatf("fair%0d d64", j), bus.wbm_dat64_o, 32'hD640_0000 + 32'(order[j]));
      tick();
      cur[order[j]] = 1'b0;
      drive(cur, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("fair%0d rel gnt", j), bus.gnt, 32'(1 << order[j]));
      chk($sformatf("fair%0d rel mcyc", j), bus.wbm_cyc_o, 32'd0);
      tick();
      cur[order[j]] = 1'b1;
      drive(cur, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("fair%0d dead gnt", j), bus.gnt, 32'd0);
      chk($sformatf("fair%0d dead st", j), arb_state, 32'd0);
      tick();
    end

    // Timeout on owner 2, then the grant moves on to 3.
    do_reset();
    drive(5'b01100, 1'b0, 1'b0, 1'b0);
    tick();
    for (int s = 1; s <= 8; s++) stall_chk("tmo", 2, s, s == 8);
    @(negedge clk);
    chk("tmo abort st", arb_state, 32'd2);
    chk("tmo abort mcyc", bus.wbm_cyc_o, 32'd0);
    chk("tmo abort mstb", bus.wbm_stb_o, 32'd0);
    chk("tmo abort gnt", bus.gnt, 32'b00100);
    chk("tmo abort err", bus.req_err, 32'd0);
    tick();
    drive(5'b01000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("tmo drop st", arb_state, 32'd2);
    chk("tmo drop gnt", bus.gnt, 32'b00100);
    tick();
    @(negedge clk);
    chk("tmo idle gnt", bus.gnt, 32'd0);
    tick();
    drive(5'b01000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("tmo next gnt", bus.gnt, 32'b01000);
    chk("tmo next mcyc", bus.wbm_cyc_o, 32'd1);
    chk("tmo next ack", bus.req_ack, 32'b01000);
    tick();
    drive(5'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Ack on the would-be timeout cycle wins and restarts the count.
    do_reset();
    drive(5'b00001, 1'b0, 1'b0, 1'b0);
    tick();
    for (int s = 1; s <= 7; s++) stall_chk("ackw", 0, s, 1'b0);
    drive(5'b00001, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("ackw ack", bus.req_ack, 32'b00001);
    chk("ackw err", bus.req_err, 32'd0);
    tick();
    drive(5'b00001, 1'b0, 1'b0, 1'b0);
    for (int s = 1; s <= 8; s++) stall_chk("ackw2", 0, s, s == 8);
    @(negedge clk);
    chk("ackw2 abort st", arb_state, 32'd2);
    tick();
    drive(5'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Cyc drop on the timeout cycle: normal release, no err.
    do_reset();
    drive(5'b00010, 1'b0, 1'b0, 1'b0);
    tick();
    for (int s = 1; s <= 7; s++) stall_chk("race", 1, s, 1'b0);
    drive(5'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("race err", bus.req_err, 32'd0);
    chk("race st", arb_state, 32'd1);
    tick();
    @(negedge clk);
    chk("race idle st", arb_state, 32'd0);
    chk("race idle err", bus.req_err, 32'd0);
    tick();

    // Async reset during beat 2 of a burst from requester 4.
    do_reset();
    drive(5'b10000, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'b10000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("arst b1 gnt", bus.gnt, 32'b10000);
    chk("arst b1 cab", bus.wbm_cab_o, 32'd1);
    tick();
    drive(5'b10001, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst gnt", bus.gnt, 32'd0);
    chk("arst mcyc", bus.wbm_cyc_o, 32'd0);
    chk("arst ack", bus.req_ack, 32'd0);
    chk("arst st", arb_state, 32'd0);
    tick();
    rst_n = 1'b1;
    drive(5'b10001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("arst rel gnt", bus.gnt, 32'd0);
    tick();
    @(negedge clk);
    chk("arst first gnt", bus.gnt, 32'b00001);
    tick();
    drive(5'b0, 1'b0, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

`default_nettype wire
